// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: group width and the 4-bit
// group generate/propagate function.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic g;
        logic p;
    } grp_gp_t;

    function automatic grp_gp_t grp_gp(
        input logic [3:0] g,
        input logic [3:0] p
    );
        grp_gp_t r;
        r.g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        r.p = &p;
        return r;
    endfunction

endpackage

// File: rtl/cla_add_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// The master drives operands and out_ready; the slave is the adder.
interface cla_add_pipe_if #(
    parameter int N = 16
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         Cout;
    logic         V;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, V
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, V
    );

endinterface

// File: rtl/cla4.sv
// 4-bit lookahead group: internal carries plus group G/P and carry-out.
module cla4
    import cla_pkg::*;
(
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_ci,
    output logic [3:1] o_c,
    output logic       o_gg,
    output logic       o_gp,
    output logic       o_co
);

    grp_gp_t w_grp;

    assign w_grp = grp_gp(i_g, i_p);

    assign o_c[1] = i_g[0]
                  | (i_p[0] & i_ci);
    assign o_c[2] = i_g[1]
                  | (i_p[1] & i_g[0])
                  | (i_p[1] & i_p[0] & i_ci);
    assign o_c[3] = i_g[2]
                  | (i_p[2] & i_g[1])
                  | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_ci);

    assign o_gg = w_grp.g;
    assign o_gp = w_grp.p;
    assign o_co = w_grp.g | (w_grp.p & i_ci);

endmodule

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder: stage 1 registers G/P,
// stage 2 resolves carries per 4-bit group and registers S/Cout/V.
module cla_add_pipe
    import cla_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    cla_add_pipe_if.slave  bus
);

    localparam int NG = N / CLA_GROUP;

    logic         r_v1;
    logic         r_c1;
    logic [N-1:0] r_g;
    logic [N-1:0] r_p;
    logic         r_v2;
    logic [N-1:0] r_s;
    logic         r_cout;
    logic         r_ovf;

    logic          w_adv1;
    logic          w_adv2;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_co;
    logic [NG:0]   w_gc;
    logic [N:0]    w_c;
    logic [N-1:0]  w_s;
    logic          w_unused_co;

    assign w_adv2 = r_v1 & (!r_v2 | bus.out_ready);
    assign w_adv1 = bus.in_valid & (!r_v1 | w_adv2);

    assign bus.in_ready  = !r_v1 | !r_v2 | bus.out_ready;
    assign bus.out_valid = r_v2;
    assign bus.S         = r_s;
    assign bus.Cout      = r_cout;
    assign bus.V         = r_ovf;

    // Group carries ripple from group G/P, one hop per group.
    always_comb begin
        w_gc    = '0;
        w_gc[0] = r_c1;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4 u_cla4 (
            .i_g  (r_g[4*k +: 4]),
            .i_p  (r_p[4*k +: 4]),
            .i_ci (w_gc[k]),
            .o_c  (w_c[4*k+1 +: 3]),
            .o_gg (w_gg[k]),
            .o_gp (w_gp[k]),
            .o_co (w_co[k])
        );
        assign w_c[4*k] = w_gc[k];
    end

    assign w_c[N] = w_gc[NG];
    assign w_s    = r_p ^ w_c[N-1:0];

    // Per-group co duplicates w_gc[k+1]; the ripple uses G/P instead.
    assign w_unused_co = ^w_co;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_c1   <= 1'b0;
            r_g    <= '0;
            r_p    <= '0;
            r_v2   <= 1'b0;
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_v2   <= 1'b1;
                r_s    <= w_s;
                r_cout <= w_c[N];
                r_ovf  <= w_c[N-1] ^ w_c[N];
            end else if (bus.out_ready && r_v2) begin
                r_v2 <= 1'b0;
            end

            if (w_adv1) begin
                r_v1 <= 1'b1;
                r_g  <= bus.A & bus.B;
                r_p  <= bus.A ^ bus.B;
                r_c1 <= bus.Cin;
            end else if (w_adv2) begin
                r_v1 <= 1'b0;
            end
        end
    end

endmodule
